// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths, fetch FSM encoding and NOOP opcode
package cpu_pkg;

  localparam int PC_W = 7;
  localparam int IW   = 16;

  localparam logic [IW-1:0] NOOP = '0;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/pc_counter.sv
// rtl/pc_counter.sv - program counter with clear-over-increment priority
module pc_counter #(
  parameter int PC_W = cpu_pkg::PC_W
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            PC_clr,
  input  logic            PC_up,
  output logic [PC_W-1:0] PC
);

  // Increment wraps naturally at 2^PC_W.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      PC <= '0;
    end else if (PC_clr) begin
      PC <= '0;
    end else if (PC_up) begin
      PC <= PC + PC_W'(1);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch: PC, IR and stale-ROM-data wait state
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int PC_W = cpu_pkg::PC_W,
  parameter int IW   = cpu_pkg::IW
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            PC_clr,
  input  logic            PC_up,
  input  logic            IR_ld,
  input  logic [IW-1:0]   imem_rdata,
  output logic [PC_W-1:0] imem_addr,
  output logic [PC_W-1:0] PC,
  output logic [IW-1:0]   instruction,
  output logic            ir_valid,
  output logic            fetch_busy
);

  state_t          state;
  state_t          state_nxt;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] fa;
  logic [PC_W-1:0] last_addr;
  logic            last_vld;
  logic            match;
  logic            ir_load;
  logic            fetch_start;

  pc_counter #(
    .PC_W(PC_W)
  ) u_pc_counter (
    .clk    (clk),
    .reset_n(reset_n),
    .PC_clr (PC_clr),
    .PC_up  (PC_up),
    .PC     (pc_q)
  );

  assign PC = pc_q;

  // ROM data is current only if the address presented last edge is still the one presented now.
  assign match = last_vld && (imem_addr == last_addr);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (IR_ld && !match) state_nxt = WAIT;
      WAIT:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    imem_addr   = (state == WAIT) ? fa : pc_q;
    fetch_busy  = (state == WAIT);
    fetch_start = (state == IDLE) && IR_ld && !match;
    ir_load     = ((state == IDLE) && IR_ld && match) || (state == WAIT);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fa          <= '0;
      last_addr   <= '0;
      last_vld    <= 1'b0;
      instruction <= IW'(NOOP);
      ir_valid    <= 1'b0;
    end else begin
      last_addr <= imem_addr;
      last_vld  <= 1'b1;
      if (fetch_start) begin
        fa <= pc_q;
      end
      if (ir_load) begin
        instruction <= imem_rdata;
        ir_valid    <= 1'b1;
      end
    end
  end

endmodule
